// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: data-memory requester with stack pointer, overflow/underflow detection and response pulse.
// Optional macro STACK_GUARD_EN rejects load/store addresses that fall inside the stack region.
module stack_mem_ctrl #(
    parameter int N           = 16,
    parameter int AW          = 9,
    parameter int STACK_TOP   = 511,
    parameter int STACK_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [N-1:0]  cmd_wdata,
    output logic          rsp_valid,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_err,
    output logic          err_ovf,
    output logic          err_unf,
    output logic [AW-1:0] stack_count,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic          mem_psh,
    output logic          mem_pop,
    output logic [AW-1:0] mem_address,
    output logic [AW-1:0] mem_stackpointer,
    output logic [N-1:0]  mem_data_in,
    input  logic [N-1:0]  mem_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam logic [1:0] OP_LD = 2'b00, OP_ST = 2'b01, OP_PSH = 2'b10, OP_POP = 2'b11;
    localparam logic [AW-1:0] TOP = AW'(STACK_TOP);
    localparam logic [AW-1:0] DEPTH = AW'(STACK_DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);

    state_t state, state_n;
    logic [1:0] op, op_n;
    logic [AW-1:0] sp, sp_n, cnt_n, addr_n;
    logic [N-1:0] din_n, data_n;
    logic wr_n, rd_n, psh_n, pop_n, valid_n, err_n, ovf_n, unf_n;
    logic full, empty, guard;

    assign cmd_ready = state == IDLE;
    assign mem_stackpointer = sp;
    assign full = cmd_op == OP_PSH && stack_count == DEPTH;
    assign empty = cmd_op == OP_POP && stack_count == '0;
`ifdef STACK_GUARD_EN
    localparam logic [AW-1:0] GUARD_LO = AW'(STACK_TOP - STACK_DEPTH + 1);
    assign guard = !cmd_op[1] && cmd_addr >= GUARD_LO && cmd_addr <= TOP;
`else
    assign guard = 1'b0;
`endif

    always_comb begin
        state_n = state;
        op_n = op;
        sp_n = sp;
        cnt_n = stack_count;
        {wr_n, rd_n, psh_n, pop_n} = '0;
        addr_n = mem_address;
        din_n = mem_data_in;
        data_n = rsp_data;
        valid_n = 1'b0;
        err_n = 1'b0;
        ovf_n = err_ovf;
        unf_n = err_unf;
        unique case (state)
            IDLE: if (cmd_valid) begin
                op_n = cmd_op;
                data_n = '0;
                if (full || empty || guard) begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    err_n = 1'b1;
                    ovf_n = err_ovf | full;
                    unf_n = err_unf | empty;
                end else begin
                    state_n = ISSUE;
                    wr_n = cmd_op == OP_ST;
                    rd_n = cmd_op == OP_LD;
                    psh_n = cmd_op == OP_PSH;
                    pop_n = cmd_op == OP_POP;
                    // push writes the free slot at SP, pop reads the last used slot at SP+1
                    addr_n = cmd_op == OP_PSH ? sp : cmd_op == OP_POP ? sp + ONE : cmd_addr;
                    din_n = cmd_wdata;
                end
            end
            ISSUE: begin
                sp_n = op == OP_PSH ? sp - ONE : op == OP_POP ? sp + ONE : sp;
                cnt_n = op == OP_PSH ? stack_count + ONE : op == OP_POP ? stack_count - ONE : stack_count;
                state_n = (op == OP_LD || op == OP_POP) ? CAPTURE : RESP;
                valid_n = !(op == OP_LD || op == OP_POP);
            end
            CAPTURE: begin
                data_n = mem_data_out;
                state_n = RESP;
                valid_n = 1'b1;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            op <= OP_LD;
            sp <= TOP;
            stack_count <= '0;
            {mem_wr, mem_rd, mem_psh, mem_pop} <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            rsp_data <= '0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            state <= state_n;
            op <= op_n;
            sp <= sp_n;
            stack_count <= cnt_n;
            {mem_wr, mem_rd, mem_psh, mem_pop} <= {wr_n, rd_n, psh_n, pop_n};
            mem_address <= addr_n;
            mem_data_in <= din_n;
            rsp_data <= data_n;
            rsp_valid <= valid_n;
            rsp_err <= err_n;
            err_ovf <= ovf_n;
            err_unf <= unf_n;
        end
    end
endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
- Requester-side controller for the 16-bit data memory.
- Accepts load/store/push/pop commands from the control unit over a valid/ready handshake and owns the stack pointer.
- Detects stack overflow/underflow, drives the memory strobes (WR, RD, psh, pop), and returns read data with a one-cycle response pulse.
- Sits between Control_Unit and the data memory; the memory responds one clock after a strobe.

Parameters:
- N, 16, data word width
- AW, 9, memory address width
- STACK_TOP, 511, empty-stack SP value; stack grows downward
- STACK_DEPTH, 64, maximum number of stacked words

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 load, 01 store, 10 push, 11 pop
- cmd_addr  input  AW  load/store address
- cmd_wdata  input  N  store/push data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_data  output  N  load/pop result; 0 for writes and errors
- rsp_err  output  1  qualifies rsp_valid; command rejected
- err_ovf  output  1  sticky push-overflow flag
- err_unf  output  1  sticky pop-underflow flag
- stack_count  output  AW  words currently on the stack
- mem_wr, mem_rd, mem_psh, mem_pop  output  1 each  memory strobes
- mem_address  output  AW  memory address
- mem_stackpointer  output  AW  current SP
- mem_data_in  output  N  write data
- mem_data_out  input  N  memory read data, valid one clock after mem_rd/mem_pop

Behaviour:
- Reset (rst==0 at posedge, any state):
  - state IDLE, all strobes 0, rsp_valid 0, rsp_err 0, rsp_data 0.
  - err_ovf 0, err_unf 0, SP=STACK_TOP, stack_count 0.
  - mem_address 0, mem_data_in 0.
  - An in-flight command is dropped with no response.
- All outputs are registered except cmd_ready (cmd_ready = state==IDLE) and mem_stackpointer (= SP).
- SP convention: SP points to the next free slot.
  - push writes mem[SP], then SP decrements.
  - pop reads mem[SP+1], then SP increments.
  - stack_count = STACK_TOP - SP.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: on cmd_valid && cmd_ready, latch op/addr/wdata.
    - Error case (push with stack_count==STACK_DEPTH, or pop with stack_count==0): go to RESP with rsp_err=1, set the matching sticky flag, assert no strobe, leave SP unchanged.
    - Otherwise go to ISSUE.
  - ISSUE (exactly 1 cycle): exactly one strobe high, with mem_address/mem_data_in valid.
    - SP updates at the end of ISSUE.
    - load/pop go to CAPTURE; store/push go to RESP.
  - CAPTURE: register mem_data_out into rsp_data; go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; return to IDLE.
- Latency from the accept edge to rsp_valid high:
  - store/push: 2 cycles.
  - load/pop: 3 cycles.
  - error: 1 cycle.
  - Throughput: one command per latency+1 cycles.
- No back-pressure on the response; the requester must accept rsp_valid when it is pulsed.
- Strobes are never asserted simultaneously.
- SP arithmetic is AW-bit; limit checks use stack_count, so SP never wraps.
- Load/store addresses are unrestricted except as described under STACK_GUARD_EN.
- Sticky flags clear only on reset.
- cmd_valid while not in IDLE is ignored; the command is not accepted because cmd_ready=0.

Optional Feature:
- Macro: STACK_GUARD_EN
- Defined: load/store with cmd_addr in [STACK_TOP-STACK_DEPTH+1, STACK_TOP] is rejected with a 1-cycle error response. No strobe is issued and no sticky flag is set.
- Undefined: no address checking; any cmd_addr is issued.

Test Plan:
- Reset, then push 0x1234 -> mem_psh for one cycle with mem_stackpointer=511, mem_data_in=0x1234. rsp_valid 2 cycles after accept; SP=510, stack_count=1.
- Push 0xAAAA, push 0x5555, pop, pop -> pops return 0x5555 then 0xAAAA. rsp_valid 3 cycles after accept; final SP=511, stack_count=0.
- Pop on empty stack -> rsp_valid with rsp_err=1 one cycle after accept, rsp_data=0, err_unf=1, no mem_pop strobe.
- 64 pushes, then a 65th push -> 65th gets rsp_err=1 and err_ovf=1, SP stays 447, stack_count stays 64.
- Store 0xBEEF @0x010, then load @0x010 -> mem_wr then mem_rd, load returns 0xBEEF. With STACK_GUARD_EN, store @0x1F0 gets rsp_err=1 and no mem_wr.
- Drive rst=0 during the ISSUE of a push -> next cycle shows IDLE, cmd_ready=1, SP=511, no rsp_valid, all flags 0.
